// File: rtl/rtc_timestamp_logger_pkg.sv
// rtl/rtc_timestamp_logger_pkg.sv - shared widths, timestamp layout and FSM states
package rtc_timestamp_logger_pkg;

    localparam int MS_W   = 10;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int TS_W   = 32;

    localparam int MS_LSB   = 0;
    localparam int SEC_LSB  = MS_LSB + MS_W;
    localparam int MIN_LSB  = SEC_LSB + SEC_W;
    localparam int HOUR_LSB = MIN_LSB + MIN_W;
    localparam int DAY_LSB  = HOUR_LSB + HOUR_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Fields are packed verbatim; out-of-range RTC values are not clamped.
    function automatic logic [TS_W-1:0] pack_ts(
        input logic [DAY_W-1:0]  day,
        input logic [HOUR_W-1:0] hour,
        input logic [MIN_W-1:0]  min,
        input logic [SEC_W-1:0]  sec,
        input logic [MS_W-1:0]   millisec
    );
        logic [TS_W-1:0] ts;
        ts = '0;
        ts[DAY_LSB  +: DAY_W]  = day;
        ts[HOUR_LSB +: HOUR_W] = hour;
        ts[MIN_LSB  +: MIN_W]  = min;
        ts[SEC_LSB  +: SEC_W]  = sec;
        ts[MS_LSB   +: MS_W]   = millisec;
        return ts;
    endfunction

endpackage

// File: rtl/rtc_timestamp_logger_if.sv
// rtl/rtc_timestamp_logger_if.sv - timestamp byte stream toward the output stage
interface rtc_timestamp_logger_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/rtc_timestamp_logger_ts_fifo.sv
// rtl/rtc_timestamp_logger_ts_fifo.sv - single-clock timestamp FIFO with registered read on pop
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wr_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rtc_timestamp_logger.sv
// rtl/rtc_timestamp_logger.sv - captures RTC timestamps on event strobes and streams them out MSB first
module rtc_timestamp_logger
    import rtc_timestamp_logger_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   event_stb,
    input  logic [MS_W-1:0]        millisec,
    input  logic [SEC_W-1:0]       sec,
    input  logic [MIN_W-1:0]       min,
    input  logic [HOUR_W-1:0]      hour,
    input  logic [DAY_W-1:0]       day,
    rtc_timestamp_logger_if.master out_if,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    input  logic                   clear_ovf
);

    state_t          state;
    logic [1:0]      byte_idx;
    logic            valid_q;
    logic            last_q;
    logic [TS_W-1:0] word;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            drop;
    logic [7:0]      cur_byte;

    // Fullness is taken before any same-cycle pop, so a full FIFO always drops.
    assign drop = event_stb && fifo_full;
    assign pop  = !fifo_empty &&
                  ((state == IDLE) ||
                   (state == SEND && out_if.out_ready && byte_idx == 2'd3));

    ts_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (event_stb),
        .wr_data (pack_ts(day, hour, min, sec, millisec)),
        .pop     (pop),
        .rd_data (word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= SEND;
                        byte_idx <= 2'd0;
                        valid_q  <= 1'b1;
                        last_q   <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_if.out_ready) begin
                        if (byte_idx == 2'd3) begin
                            byte_idx <= 2'd0;
                            last_q   <= 1'b0;
                            if (fifo_empty) begin
                                state   <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            last_q   <= (byte_idx == 2'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            2'd0: cur_byte = word[31:24];
            2'd1: cur_byte = word[23:16];
            2'd2: cur_byte = word[15:8];
            2'd3: cur_byte = word[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign out_if.out_data  = valid_q ? cur_byte : 8'h00;

    // A drop in the same cycle as clear_ovf restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_count <= DROP_W'(1);
            end else if (!(&drop_count)) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_rtc_timestamp_logger.sv
// tb/tb_rtc_timestamp_logger.sv - randomized bench for rtc_timestamp_logger against a queue-based reference model
module tb_rtc_timestamp_logger;

    localparam int DEPTH    = 4;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   event_stb = 1'b0;
    logic                   clear_ovf = 1'b0;
    logic [9:0]             millisec = '0;
    logic [5:0]             sec = '0;
    logic [5:0]             min = '0;
    logic [4:0]             hour = '0;
    logic [4:0]             day = '0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_count;

    rtc_timestamp_logger_if bus();

    rtc_timestamp_logger #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .event_stb  (event_stb),
        .millisec   (millisec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .day        (day),
        .out_if     (bus.master),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int unsigned stored[$];
    int unsigned cur_word;
    bit          busy;
    int          bidx;
    bit          m_ovf;
    int          m_drops;
    bit          model_ok = 1'b0;
    bit          m_full, m_hs, m_pop, m_drop;

    logic [31:0] rx_word;
    int          words_seen;

    function automatic int unsigned pack_model(int unsigned d, int unsigned h, int unsigned m,
                                               int unsigned s, int unsigned ms);
        return d * 134217728 + h * 4194304 + m * 65536 + s * 1024 + ms;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of stored words plus the word currently on the wire.
    always @(posedge clk) begin
        if (reset) begin
            stored.delete();
            busy     = 1'b0;
            bidx     = 0;
            m_ovf    = 1'b0;
            m_drops  = 0;
            model_ok = 1'b1;
        end else begin
            m_full = (stored.size() == DEPTH);
            m_hs   = busy && bus.out_ready;
            m_pop  = (stored.size() > 0) && (!busy || (m_hs && bidx == 3));
            m_drop = event_stb && m_full;
            if (m_pop) begin
                cur_word = stored.pop_front();
                busy     = 1'b1;
                bidx     = 0;
            end else if (m_hs) begin
                if (bidx == 3) busy = 1'b0;
                else bidx++;
            end
            if (event_stb && !m_full)
                stored.push_back(pack_model(day, hour, min, sec, millisec));
            if (m_drop) begin
                m_ovf   = 1'b1;
                m_drops = clear_ovf ? 1 : ((m_drops == DROP_MAX) ? DROP_MAX : m_drops + 1);
            end else if (clear_ovf) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
    end

    task automatic check_cycle();
        int unsigned exp_byte;
        exp_byte = busy ? ((cur_word >> (8 * (3 - bidx))) & 32'hFF) : 0;
        check("out_valid", bus.out_valid, busy);
        check("out_data", bus.out_data, exp_byte);
        check("out_last", bus.out_last, busy && bidx == 3);
        check("fifo_count", fifo_count, stored.size());
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drops);
    endtask

    task automatic step(input bit stb, input bit rdy, input bit clr, input bit rst);
        event_stb     = stb;
        bus.out_ready = rdy;
        clear_ovf     = clr;
        reset         = rst;
        if (!rst && bus.out_valid === 1'b1 && rdy) begin
            rx_word = {rx_word[23:0], bus.out_data};
            if (bus.out_last === 1'b1) words_seen++;
        end
        @(negedge clk);
        if (model_ok) check_cycle();
    endtask

    task automatic set_rtc(input int d, input int h, input int m, input int s, input int ms);
        day = 5'(d); hour = 5'(h); min = 6'(m); sec = 6'(s); millisec = 10'(ms);
    endtask

    task automatic rand_rtc();
        set_rtc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                $urandom_range(0, 63), $urandom_range(0, 1023));
    endtask

    initial begin
        bus.out_ready = 1'b0;
        rx_word       = '0;
        words_seen    = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // single word, ready held high
        set_rtc(3, 14, 25, 36, 789);
        rx_word = '0;
        step(1, 1, 0, 0);
        repeat (6) step(0, 1, 0, 0);
        check("basic_word", rx_word, 32'h1B99_9315);

        // ready toggling every cycle
        rx_word = '0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, i[0], 0, 0);
        check("backpressure_word", rx_word, 32'h1B99_9315);

        // DEPTH+2 events with the sink stalled
        words_seen = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rand_rtc();
            step(1, 0, 0, 0);
        end
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_drops", drop_count, 1);
        repeat (30) step(0, 1, 0, 0);
        check("ovf_words", words_seen, DEPTH + 1);

        // three events one cycle apart
        for (int i = 0; i < 3; i++) begin
            rand_rtc();
            step(1, 1, 0, 0);
            step(0, 1, 0, 0);
        end
        repeat (12) step(0, 1, 0, 0);

        // drop counter saturation and clear
        step(0, 1, 1, 0);
        for (int i = 0; i < DEPTH + 301; i++) step(1, 0, 0, 0);
        check("sat_drops", drop_count, DROP_MAX);
        step(1, 0, 1, 0);
        check("clr_drop_ovf", overflow, 1'b1);
        check("clr_drop_cnt", drop_count, 1);
        step(0, 0, 1, 0);
        check("clr_ovf", overflow, 1'b0);
        check("clr_cnt", drop_count, 0);
        repeat (30) step(0, 1, 0, 0);

        // reset after the second byte handshake
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        step(0, 0, 0, 0);
        rx_word    = '0;
        words_seen = 0;
        set_rtc(30, 23, 59, 59, 999);
        step(1, 1, 0, 0);
        repeat (7) step(0, 1, 0, 0);
        check("post_rst_word", rx_word, pack_model(30, 23, 59, 59, 999));
        check("post_rst_words", words_seen, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_rtc();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
